// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge port for mem_access_unit.
// master = access controller, slave = data memory.
interface mem_access_unit_if #(
    parameter int unsigned B = 32
);
    logic         mem_req_out;
    logic         mem_we_out;
    logic [B-1:0] mem_addr_out;
    logic [B-1:0] mem_wdata_out;
    logic [3:0]   mem_be_out;
    logic         mem_ack_in;
    logic [B-1:0] mem_rdata_in;

    modport master (
        output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_be_out,
        input  mem_ack_in, mem_rdata_in
    );

    modport slave (
        input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_be_out,
        output mem_ack_in, mem_rdata_in
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access controller: single-outstanding req/ack data-memory access with byte steering.
// Optional macro MEM_ACCESS_ALIGN_CHECK_EN enables misaligned half/word detection.
module mem_access_unit #(
    parameter int unsigned B = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [B-1:0] alu_result_in,
    input  logic [B-1:0] r_data2_in,
    input  logic         m_MemRead_in,
    input  logic         m_MemWrite_in,
    input  logic [5:0]   opcode_in,
    output logic         stall_out,
    output logic [B-1:0] rdata_out,
    output logic         done_out,
    output logic         misalign_out,
    mem_access_unit_if.master mem_if
);
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t       r_state;
    size_t        r_size;
    logic         r_unsigned;
    logic [1:0]   r_off;
    logic         r_req, r_we, r_done, r_misalign;
    logic [B-1:0] r_addr, r_wdata, r_rdata;
    logic [3:0]   r_be;

    size_t        w_size;
    logic         w_unsigned, w_any, w_misalign, w_valid;
    logic [1:0]   w_off;
    logic [3:0]   w_be;
    logic [B-1:0] w_wdata, w_shifted, w_load;

    // Decode access kind, size and effective byte offset; a write wins over a read.
    always_comb begin
        w_size     = SZ_WORD;
        w_unsigned = 1'b0;
        w_any      = m_MemRead_in | m_MemWrite_in;
        if (m_MemWrite_in) begin
            case (opcode_in)
                OP_SB:   w_size = SZ_BYTE;
                OP_SH:   w_size = SZ_HALF;
                default: w_size = SZ_WORD;
            endcase
        end else begin
            case (opcode_in)
                OP_LB:   w_size = SZ_BYTE;
                OP_LBU:  begin w_size = SZ_BYTE; w_unsigned = 1'b1; end
                OP_LH:   w_size = SZ_HALF;
                OP_LHU:  begin w_size = SZ_HALF; w_unsigned = 1'b1; end
                default: w_size = SZ_WORD;
            endcase
        end
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        w_misalign = w_any && (((w_size == SZ_HALF) && alu_result_in[0]) ||
                               ((w_size == SZ_WORD) && (alu_result_in[1:0] != 2'b00)));
`else
        w_misalign = 1'b0;
`endif
        w_valid = w_any && !w_misalign;
        case (w_size)
            SZ_BYTE: w_off = alu_result_in[1:0];
            SZ_HALF: w_off = {alu_result_in[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end

    // Store lane steering; loads always enable the whole word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_data2_in;
        if (m_MemWrite_in) begin
            case (w_size)
                SZ_BYTE: begin
                    w_be    = 4'(4'b0001 << w_off);
                    w_wdata = {4{r_data2_in[7:0]}};
                end
                SZ_HALF: begin
                    w_be    = 4'(4'b0011 << w_off);
                    w_wdata = {2{r_data2_in[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Load extraction uses the latched offset so the half/byte lands at bit 0.
    always_comb begin
        w_shifted = mem_if.mem_rdata_in >> {r_off, 3'b000};
        case (r_size)
            SZ_BYTE: w_load = {{(B-8){w_shifted[7] & ~r_unsigned}}, w_shifted[7:0]};
            SZ_HALF: w_load = {{(B-16){w_shifted[15] & ~r_unsigned}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_size     <= SZ_WORD;
            r_unsigned <= 1'b0;
            r_off      <= 2'b00;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_be       <= 4'b0000;
        end else begin
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_misalign <= w_misalign;
                    if (w_valid) begin
                        r_state    <= S_ACCESS;
                        r_req      <= 1'b1;
                        r_we       <= m_MemWrite_in;
                        r_size     <= w_size;
                        r_unsigned <= w_unsigned;
                        r_off      <= w_off;
                        r_addr     <= {alu_result_in[B-1:2], 2'b00};
                        r_wdata    <= w_wdata;
                        r_be       <= w_be;
                    end
                end
                S_ACCESS: begin
                    if (mem_if.mem_ack_in) begin
                        r_state <= S_DONE;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        if (!r_we) r_rdata <= w_load;
                    end
                end
                // The instruction still held in EX/MEM here has already been serviced.
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall_out            = ((r_state == S_IDLE) && w_valid) || (r_state == S_ACCESS);
    assign rdata_out            = r_rdata;
    assign done_out             = r_done;
    assign misalign_out         = r_misalign;
    assign mem_if.mem_req_out   = r_req;
    assign mem_if.mem_we_out    = r_we;
    assign mem_if.mem_addr_out  = r_addr;
    assign mem_if.mem_wdata_out = r_wdata;
    assign mem_if.mem_be_out    = r_be;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized accesses against an arithmetic model.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu, d2;
    logic        rd, wr;
    logic [5:0]  op;
    logic        stall, done, misalign;
    logic [31:0] rdata;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_rdata = 32'h0;

    mem_access_unit_if #(.B(32)) mem_if ();

    mem_access_unit #(.B(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_result_in (alu),
        .r_data2_in    (d2),
        .m_MemRead_in  (rd),
        .m_MemWrite_in (wr),
        .opcode_in     (op),
        .stall_out     (stall),
        .rdata_out     (rdata),
        .done_out      (done),
        .misalign_out  (misalign),
        .mem_if        (mem_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes from opcode and direction.
    function automatic int unsigned m_size(input logic [5:0] o, input bit is_w);
        if (is_w) return (o == 6'h28) ? 1 : (o == 6'h29) ? 2 : 4;
        return (o == 6'h20 || o == 6'h24) ? 1 : (o == 6'h21 || o == 6'h25) ? 2 : 4;
    endfunction

    function automatic bit m_misaligned(input int unsigned sz, input logic [31:0] a);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        return (a % sz) != 0;
`else
        return (sz == 0) && (a == 32'h0);
`endif
    endfunction

    function automatic int unsigned m_off(input int unsigned sz, input logic [31:0] a);
        if (sz == 1) return a % 4;
        if (sz == 2) return ((a % 4) / 2) * 2;
        return 0;
    endfunction

    function automatic logic [31:0] m_mask(input int unsigned sz);
        return (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    endfunction

    function automatic logic [31:0] m_load(input logic [5:0] o, input logic [31:0] a, input logic [31:0] w);
        int unsigned sz  = m_size(o, 1'b0);
        logic [31:0] msk = m_mask(sz);
        logic [31:0] v   = (w >> (8 * m_off(sz, a))) & msk;
        bit          sgn = (o == 6'h20 || o == 6'h21);
        if (sgn && sz < 4 && ((v >> (8 * sz - 1)) & 32'd1) == 32'd1) v = v | ~msk;
        return v;
    endfunction

    // One EX/MEM instruction presented until the pipeline would advance.
    task automatic run_access(input logic [5:0] o, input logic rq, input logic wq,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] rw, input int waits);
        bit          is_w   = wq;
        bit          is_acc = rq | wq;
        int unsigned sz     = m_size(o, is_w);
        bit          mis    = is_acc && m_misaligned(sz, a);
        int unsigned off    = m_off(sz, a);
        logic [31:0] ebe    = is_w ? 32'((((1 << sz) - 1) << off) & 15) : 32'hF;
        logic [31:0] ewd    = (sz == 1) ? (d & 32'hFF) * 32'h0101_0101 :
                              (sz == 2) ? (d & 32'hFFFF) * 32'h0001_0001 : d;
        int          nst    = 0;
        @(posedge clk); #1;
        alu = a; d2 = d; op = o; rd = rq; wr = wq;
        mem_if.mem_rdata_in = rw; mem_if.mem_ack_in = 1'b0;
        #1;
        if (!is_acc || mis) begin
            check("idle_stall", 32'(stall), 32'd0);
            @(posedge clk); #1;
            check("idle_no_req", 32'(mem_if.mem_req_out), 32'd0);
            check("misalign_pulse", 32'(misalign), 32'(mis));
            rd = 1'b0; wr = 1'b0;
            @(posedge clk); #1;
            check("misalign_clear", 32'(misalign), 32'd0);
            check("idle_no_done", 32'(done), 32'd0);
            return;
        end
        if (stall === 1'b1) nst++;
        check("detect_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        check("req", 32'(mem_if.mem_req_out), 32'd1);
        check("we", 32'(mem_if.mem_we_out), 32'(is_w));
        check("addr", mem_if.mem_addr_out, a & 32'hFFFF_FFFC);
        check("be", 32'(mem_if.mem_be_out), ebe);
        if (is_w) check("wdata", mem_if.mem_wdata_out, ewd);
        check("no_misalign", 32'(misalign), 32'd0);
        for (int i = 0; i < waits; i++) begin
            if (stall === 1'b1) nst++;
            @(posedge clk); #1;
            check("req_held", 32'(mem_if.mem_req_out), 32'd1);
            check("be_held", 32'(mem_if.mem_be_out), ebe);
        end
        if (stall === 1'b1) nst++;
        mem_if.mem_ack_in = 1'b1;
        @(posedge clk); #1;
        if (!is_w) exp_rdata = m_load(o, a, rw);
        check("done", 32'(done), 32'd1);
        check("done_req_low", 32'(mem_if.mem_req_out), 32'd0);
        check("done_stall_low", 32'(stall), 32'd0);
        check("rdata", rdata, exp_rdata);
        check("stall_cycles", 32'(nst), 32'(2 + waits));
        rd = 1'b0; wr = 1'b0; mem_if.mem_ack_in = 1'b0;
        @(posedge clk); #1;
        check("done_clear", 32'(done), 32'd0);
        check("idle_req_low", 32'(mem_if.mem_req_out), 32'd0);
    endtask

    localparam int unsigned NOPS = 8;
    logic [5:0] ops [NOPS] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

    initial begin
        reset = 1'b0; alu = '0; d2 = '0; rd = 1'b0; wr = 1'b0; op = '0;
        mem_if.mem_ack_in = 1'b0; mem_if.mem_rdata_in = '0;
        #1;
        check("rst_req", 32'(mem_if.mem_req_out), 32'd0);
        check("rst_we", 32'(mem_if.mem_we_out), 32'd0);
        check("rst_addr", mem_if.mem_addr_out, 32'h0);
        check("rst_wdata", mem_if.mem_wdata_out, 32'h0);
        check("rst_be", 32'(mem_if.mem_be_out), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        mem_if.mem_ack_in = 1'b1;
        @(posedge clk); #1;
        mem_if.mem_ack_in = 1'b0;
        check("idle_ack_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("idle_ack_done2", 32'(done), 32'd0);
        check("idle_ack_req", 32'(mem_if.mem_req_out), 32'd0);

        run_access(6'h28, 1'b0, 1'b1, 32'h103, 32'h0000_00A5, 32'h0, 0);
        check("sb_be_const", 32'(mem_if.mem_be_out), 32'h8);
        check("sb_wdata_const", mem_if.mem_wdata_out, 32'hA5A5_A5A5);
        check("sb_addr_const", mem_if.mem_addr_out, 32'h100);

        run_access(6'h20, 1'b1, 1'b0, 32'h102, 32'h0, 32'h1280_FF34, 3);
        check("lb_const", rdata, 32'hFFFF_FF80);
        run_access(6'h25, 1'b1, 1'b0, 32'h202, 32'h0, 32'h8001_ABCD, 1);
        check("lhu_const", rdata, 32'h0000_8001);
        run_access(6'h21, 1'b1, 1'b0, 32'h202, 32'h0, 32'h8001_ABCD, 0);
        check("lh_const", rdata, 32'hFFFF_8001);
        run_access(6'h29, 1'b0, 1'b1, 32'h302, 32'h1234_5678, 32'h0, 2);
        check("sh_rdata_held", rdata, 32'hFFFF_8001);

        run_access(6'h23, 1'b1, 1'b0, 32'h101, 32'h0, 32'hCAFE_F00D, 0);
`ifndef MEM_ACCESS_ALIGN_CHECK_EN
        check("lw_unaligned_addr", mem_if.mem_addr_out, 32'h100);
        check("lw_unaligned_data", rdata, 32'hCAFE_F00D);
`endif

        // Reset in the middle of a pending request.
        @(posedge clk); #1;
        alu = 32'h80; d2 = 32'h1111_2222; op = 6'h2B; wr = 1'b1; rd = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_req", 32'(mem_if.mem_req_out), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_req", 32'(mem_if.mem_req_out), 32'd0);
        check("mid_rst_be", 32'(mem_if.mem_be_out), 32'h0);
        check("mid_rst_rdata", rdata, 32'h0);
        exp_rdata = 32'h0;
        wr = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        run_access(6'h2B, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0, 1);
        check("sw_be_const", 32'(mem_if.mem_be_out), 32'hF);

        for (int n = 0; n < 60; n++) begin
            logic [5:0]  ro;
            logic        rrd, rwr;
            int unsigned sel;
            ro  = ($urandom % 6 == 0) ? 6'($urandom) : ops[$urandom % NOPS];
            sel = $urandom % 8;
            rrd = (sel != 0) && (sel % 2 == 1 || sel == 6);
            rwr = (sel != 0) && (sel % 2 == 0 || sel == 7);
            run_access(ro, rrd, rwr, $urandom, $urandom, $urandom, int'($urandom % 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller consuming the EX/MEM pipeline register outputs. Turns the latched address, store data, MemRead/MemWrite and opcode into a single-outstanding, variable-latency request/acknowledge transaction on the data-memory port. Performs byte-lane steering for stores and extraction plus sign/zero extension for loads. Holds the upstream pipeline registers through `stall_out` until the access completes.

## Interface
Parameters:
- `B`, 32, data/address width; byte-lane logic is fixed for B=32

Ports:
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `alu_result_in`  in  B  effective byte address from EX/MEM
- `r_data2_in`  in  B  store data from EX/MEM
- `m_MemRead_in`  in  1  load request from EX/MEM
- `m_MemWrite_in`  in  1  store request from EX/MEM
- `opcode_in`  in  6  MIPS opcode from EX/MEM
- `stall_out`  out  1  high = hold IF/ID, ID/EX and EX/MEM (`ena` low)
- `rdata_out`  out  B  extended load data, registered
- `done_out`  out  1  one-cycle pulse when an access completes
- `misalign_out`  out  1  one-cycle pulse for a misaligned access
- `mem_req_out`  out  1  request to data memory, registered
- `mem_we_out`  out  1  1 = write, 0 = read, valid with request
- `mem_addr_out`  out  B  word address: `alu_result_in` with bits [1:0] forced to 0
- `mem_wdata_out`  out  B  lane-replicated store data
- `mem_be_out`  out  4  byte enables; bit i = bits [8i+7:8i]
- `mem_ack_in`  in  1  memory completion; read data valid the same cycle
- `mem_rdata_in`  in  B  read word from memory

## Operation
- Opcodes: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
- Any other opcode with MemRead set is treated as LW. Any other opcode with MemWrite set is treated as SW.
- Byte order is little-endian: lane = addr[1:0].
- An access is valid in IDLE when MemRead or MemWrite is high and the access is not misaligned. If both are high, the write wins.
- FSM:
  - IDLE: on a valid access, latch the operation, lane, address, wdata and be, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: `mem_req_out` is 1. On `mem_ack_in` = 1, capture the extended read data (loads only) and go to DONE.
  - DONE: pulse `done_out`, then go to IDLE unconditionally. The instruction still present in EX/MEM during DONE is not restarted.
- `stall_out` is combinational: (IDLE and valid access) or ACCESS. It is 0 in DONE, so EX/MEM advances at the end of DONE.
- Stores:
  - SB: be = 1<<lane, wdata = byte replicated 4×.
  - SH: be = addr[1] ? 1100 : 0011, wdata = half replicated 2×.
  - SW: be = 1111.
- Loads: be = 1111 on the request.
  - LB/LBU: select the byte at `lane`, then sign- or zero-extend.
  - LH/LHU: select the half at `addr[1]`, then sign- or zero-extend.
  - LW: pass the word through.
- `rdata_out` holds its last load value across stores and idle cycles.
- `mem_ack_in` is ignored outside ACCESS. An ack held high captures once only.

## Timing
- Reset (async, active-low) has immediate effect:
  - state = IDLE
  - `mem_req_out`, `mem_we_out`, `done_out`, `misalign_out` = 0
  - `mem_addr_out`, `mem_wdata_out`, `rdata_out` = 0
  - `mem_be_out` = 0000
  - `stall_out` = 0 apart from its combinational term
- Reset mid-ACCESS abandons the transaction and drops the request in the same cycle.
- Latency with zero-wait ack:
  - cycle 0: IDLE detect, `stall_out` = 1
  - cycle 1: ACCESS with ack
  - cycle 2: DONE, `done_out` = 1, `rdata_out` valid
- Total is 3 cycles with stall high for 2. Each wait cycle before ack adds one ACCESS cycle.
- Request fields (`mem_we_out`, addr, wdata, be) are stable from entry to ACCESS until ack.
- `misalign_out` is a registered pulse one cycle after detection in IDLE. It raises no stall and no request, and the pipeline advances.

## Configuration
- `MEM_ACCESS_ALIGN_CHECK_EN` defined:
  - LH/LHU/SH with addr[0] = 1 is misaligned.
  - LW/SW with addr[1:0] ≠ 0 is misaligned.
  - A misaligned access gives a `misalign_out` pulse and no access.
- Undefined:
  - `misalign_out` is tied 0.
  - Offending low bits are ignored: a half uses addr[1] only, a word uses lane 0. The access proceeds normally.

## Test plan
- Reset then release: every output at its reset value. `mem_ack_in` pulsed in IDLE → no `done_out`.
- SB, addr 0x103, data 0x000000A5, ack on first ACCESS cycle:
  - request fields: `mem_addr_out` = 0x100, `mem_be_out` = 1000, `mem_wdata_out` = 0xA5A5A5A5, `mem_we_out` = 1
  - control: stall high 2 cycles, `done_out` on cycle 2
- LB, addr 0x102, `mem_rdata_in` = 0x1280FF34, ack after 3 wait cycles:
  - `rdata_out` = 0xFFFFFF80
  - stall high 5 cycles
- LHU, addr 0x202, `mem_rdata_in` = 0x8001ABCD: `rdata_out` = 0x00008001. LH, same stimulus: `rdata_out` = 0xFFFF8001.
- `MEM_ACCESS_ALIGN_CHECK_EN` defined, LW at 0x101:
  - no `mem_req_out`, `stall_out` stays 0
  - `misalign_out` high exactly 1 cycle
- Undefined, same stimulus: LW is issued with `mem_addr_out` = 0x100.
- Reset asserted during ACCESS: `mem_req_out` falls immediately, state returns to IDLE. A following SW at 0x40 then completes normally with `mem_be_out` = 1111.
